// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: data_memory alucodes,
// FSM state encoding, the latched request record and access-size helpers.
package load_store_unit_pkg;

  localparam logic [5:0] ALU_LB  = 6'd18;
  localparam logic [5:0] ALU_LH  = 6'd19;
  localparam logic [5:0] ALU_LW  = 6'd20;
  localparam logic [5:0] ALU_LBU = 6'd21;
  localparam logic [5:0] ALU_LHU = 6'd22;
  localparam logic [5:0] ALU_SB  = 6'd23;
  localparam logic [5:0] ALU_SH  = 6'd24;
  localparam logic [5:0] ALU_SW  = 6'd25;

  typedef enum logic [2:0] {
    LSU_IDLE = 3'd0,
    LSU_ACC  = 3'd1,
    LSU_LO   = 3'd2,
    LSU_HI   = 3'd3,
    LSU_SB   = 3'd4
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [5:0]  alucode;
    logic        is_load;
    logic        is_store;
    logic [4:0]  rd;
  } lsu_req_t;

  // Index of the last byte touched by an access (0 byte, 1 half, 3 word).
  function automatic logic [1:0] last_byte_idx(input logic [5:0] alucode);
    case (alucode)
      ALU_LB, ALU_LBU, ALU_SB: last_byte_idx = 2'd0;
      ALU_LH, ALU_LHU, ALU_SH: last_byte_idx = 2'd1;
      default:                 last_byte_idx = 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [5:0] alucode, input logic [1:0] off);
    case (last_byte_idx(alucode))
      2'd1:    is_misaligned = (off == 2'd3);
      2'd3:    is_misaligned = (off != 2'd0);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Merges two adjacent memory words, shifts the addressed bytes down and
// sign- or zero-extends them according to the load alucode.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [1:0]  off,
  input  logic [5:0]  alucode,
  output logic [31:0] result
);

  logic [63:0] merged;

  assign merged = {hi, lo} >> {off, 3'b000};

  always_comb begin
    case (alucode)
      ALU_LB:  result = {{24{merged[7]}}, merged[7:0]};
      ALU_LBU: result = {24'h0, merged[7:0]};
      ALU_LH:  result = {{16{merged[15]}}, merged[15:0]};
      ALU_LHU: result = {16'h0, merged[15:0]};
      default: result = merged[31:0];
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request per handshake and drives data_memory,
// splitting word-crossing loads into two word reads and stores into byte writes.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [5:0]  req_alucode,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [5:0]  mem_alucode,
  output logic        mem_is_load,
  output logic        mem_is_store,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] lo_q, lo_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        accept;
  logic        req_legal;
  logic        in_hi;
  logic [31:0] word_base;
  logic [31:0] align_lo;
  logic [31:0] align_hi;
  logic [1:0]  align_off;
  logic [31:0] align_result;

  assign accept    = req_valid && req_ready;
  assign req_legal = req_is_load ^ req_is_store;
  assign word_base = {req_q.addr[31:2], 2'b00};

  // ACC reuses the aligner with a single already-extended word at offset 0.
  assign in_hi     = (state_q == LSU_HI);
  assign align_lo  = in_hi ? lo_q : mem_rdata;
  assign align_hi  = in_hi ? mem_rdata : 32'h0;
  assign align_off = in_hi ? req_q.addr[1:0] : 2'd0;

  lsu_load_align u_load_align (
    .lo      (align_lo),
    .hi      (align_hi),
    .off     (align_off),
    .alucode (req_q.alucode),
    .result  (align_result)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    lo_d         = lo_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    req_ready    = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    mem_alucode  = 6'h0;
    mem_is_load  = 1'b0;
    mem_is_store = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        req_ready = 1'b1;
        // Requests with neither or both flags are consumed without any effect.
        if (accept && req_legal) begin
          req_d = '{addr:     req_addr,
                    wdata:    req_wdata,
                    alucode:  req_alucode,
                    is_load:  req_is_load,
                    is_store: req_is_store,
                    rd:       req_rd};
          cnt_d  = 2'd0;
          last_d = last_byte_idx(req_alucode);
          if (!is_misaligned(req_alucode, req_addr[1:0])) begin
            state_d = LSU_ACC;
          end else if (req_is_load) begin
            state_d = LSU_LO;
          end else begin
            state_d = LSU_SB;
          end
        end
      end

      LSU_ACC: begin
        mem_addr     = req_q.addr;
        mem_wdata    = req_q.wdata;
        mem_alucode  = req_q.alucode;
        mem_is_load  = req_q.is_load;
        mem_is_store = req_q.is_store;
        if (req_q.is_load) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = req_q.rd;
          wb_data_d  = align_result;
        end
        state_d = LSU_IDLE;
      end

      LSU_LO: begin
        mem_addr    = word_base;
        mem_alucode = ALU_LW;
        mem_is_load = 1'b1;
        lo_d        = mem_rdata;
        state_d     = LSU_HI;
      end

      LSU_HI: begin
        mem_addr    = word_base + 32'd4;
        mem_alucode = ALU_LW;
        mem_is_load = 1'b1;
        wb_valid_d  = 1'b1;
        wb_rd_d     = req_q.rd;
        wb_data_d   = align_result;
        state_d     = LSU_IDLE;
      end

      LSU_SB: begin
        mem_addr     = req_q.addr + {30'h0, cnt_q};
        mem_wdata    = {24'h0, req_q.wdata[{cnt_q, 3'b000} +: 8]};
        mem_alucode  = ALU_SB;
        mem_is_store = 1'b1;
        cnt_d        = cnt_q + 2'd1;
        if (cnt_q == last_q) begin
          state_d = LSU_IDLE;
        end
      end

      default: state_d = LSU_IDLE;
    endcase

    // A byte write issued in the reset cycle must not commit.
    if (rst) begin
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;
      mem_alucode  = 6'h0;
      mem_is_load  = 1'b0;
      mem_is_store = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample the same edge.
    if (rst) begin
      state_q    <= LSU_IDLE;
      req_q      <= '0;
      cnt_q      <= 2'd0;
      last_q     <= 2'd0;
      lo_q       <= 32'h0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'h0;
      wb_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      lo_q       <= lo_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and `data_memory`. Accepts one memory request per handshake, issues it to `data_memory`, and returns load results to writeback. Accesses that cross a 32-bit word boundary are split into legal `data_memory` operations:
- misaligned loads become two aligned `ALU_LW` reads, which are merged and extended;
- misaligned stores become a sequence of `ALU_SB` writes.

## Interface
Parameters: none (32-bit addresses/data, 6-bit alucode, 5-bit rd are fixed).
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present from execute
- `req_ready`  out  1  unit can accept; high only in IDLE
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data (low bytes used for SB/SH)
- `req_alucode`  in  6  `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW`
- `req_is_load`  in  1  load request
- `req_is_store`  in  1  store request
- `req_rd`  in  5  load destination register
- `mem_addr`  out  32  to `data_memory.addr`
- `mem_wdata`  out  32  to `data_memory.data_in`
- `mem_alucode`  out  6  to `data_memory.alucode`
- `mem_is_load`  out  1  to `data_memory.is_load`
- `mem_is_store`  out  1  to `data_memory.is_store`
- `mem_rdata`  in  32  from `data_memory.data_out` (combinational, same cycle)
- `wb_valid`  out  1  one-cycle pulse: load result valid
- `wb_rd`  out  5  destination of result
- `wb_data`  out  32  extended load result

## Operation
- **Handshake:** accept when `req_valid && req_ready`. The unit latches `addr`, `wdata`, `alucode`, flags, `rd`, and `off = addr[1:0]`.
- **Misalignment:**
  - `LH/LHU/SH` is misaligned when `off==3`.
  - `LW/SW` is misaligned when `off!=0`.
  - Byte ops are never misaligned.
- **Invalid flag combinations:**
  - Neither flag set: accepted, no memory activity, no `wb_valid`, stays in IDLE.
  - Both flags set: same no-op treatment.
- **FSM states:**
  - **IDLE:** `mem_*` all 0, `req_ready=1`. On accept:
    - aligned → ACC
    - misaligned load → LO
    - misaligned store → SB, with `cnt=0` and `n` = 2 for halfword or 4 for word
  - **ACC:** drives `mem_*` with the latched request unchanged. For a load, captures `mem_rdata` into `wb_data` and `rd` into `wb_rd`, and sets `wb_valid` next cycle. → IDLE.
  - **LO:** `mem_addr = {addr[31:2],2'b00}`, `ALU_LW`, `mem_is_load=1`; captures `lo`. → HI.
  - **HI:** `mem_addr = {addr[31:2],2'b00} + 4` (wraps modulo 2^32), `ALU_LW`. Merged = `{mem_rdata, lo} >> (8*off)`, low 8/16/32 bits, sign- or zero-extended per alucode. Result goes to `wb_data`/`wb_rd`, `wb_valid` next cycle. → IDLE.
  - **SB:** `mem_addr = addr + cnt` (wraps), `ALU_SB`, `mem_is_store=1`, `mem_wdata = {24'b0, wdata[8*cnt+7 -: 8]}`. `cnt` increments each cycle; → IDLE after `cnt==n-1`.
- **Outputs:** stores never assert `wb_valid`. `wb_data`/`wb_rd` hold their value until the next load result.
- **Reset:** returns to IDLE, clears `cnt`, `lo`, `wb_valid`, `wb_data`, `wb_rd`, and all `mem_*`. Bytes already written by an interrupted SB sequence stay written; the rest are dropped.

## Timing
- **Reset values:**
  - `req_ready=1` (IDLE)
  - `wb_valid=0`, `wb_data=0`, `wb_rd=0`
  - `mem_addr=0`, `mem_wdata=0`, `mem_alucode=0`, `mem_is_load=0`, `mem_is_store=0`
- **Aligned access:** accepted in cycle T, memory driven in T+1 (store commits at end of T+1), `wb_valid` high in T+2. Throughput is 1 request per 2 cycles.
- **Misaligned load:** LO in T+1, HI in T+2, `wb_valid` in T+3.
- **Misaligned store:** SB cycles T+1 … T+n. `req_ready` returns in T+n+1.
- **Busy:** `req_ready=0` in every non-IDLE state; `req_valid` is ignored then.
- **Back-to-back:** a new request may be accepted in the same cycle `wb_valid` pulses.
- **Reset priority:** `rst` overrides every transition in the same edge, including an accept.

## Structure
- The alucode constants stay in the shared `define.vh`.
- FSM state encodings (`LSU_IDLE/ACC/LO/HI/SB`) are added to `define.vh`.
- Sub-module `lsu_load_align` (combinational): inputs `lo`, `hi`, `off`, `alucode` → 32-bit extended result. It is used in both ACC (`hi = 0`, `lo = mem_rdata`, `off = 0`) and HI.

## Test plan
Memory preload: `mem[0]=0x44332211`, `mem[1]=0x88776655`, `mem[2]=0x000000AA`.
- LW addr 4, aligned → `wb_valid` at T+2, `wb_data=0x88776655`.
- LW addr 1 → LO reads addr 0, HI reads addr 4; `wb_data=0x55443322` at T+3.
- LH addr 7 → `0xFFFFAA88`; LHU addr 7 → `0x0000AA88`; LB addr 7 → `0xFFFFFF88`.
- SW `0xDDCCBBAA` to addr 6 → SB at addr 6, 7, 8, 9 with data AA, BB, CC, DD; then `mem[1]=0xBBAA6655`, `mem[2]=0x0000DDCC`; no `wb_valid`; `req_ready` low 4 cycles.
- Same SW with `rst` asserted in the 3rd SB cycle → `mem[1]=0xBBAA6655`, `mem[2]=0x000000AA`; all outputs at reset values next cycle.
- `req_valid` held with SB@0 (`wdata` 0x11), then LBU@0 → second request accepted in the first IDLE cycle; `wb_data=0x00000011`.
